uart_packet_rx: RTL and testbench

Serial front end of the GPU's input assembler. Receives 8N1 UART bytes from the host PC on `ui_in[3]` and tags each byte with its position in the fixed-length scene packet. Each accepted byte drives the top-level parameter register bank through `read_data`/`idx`/`update_reg`. `pc_ready` marks a complete packet so the vertex stage can start its recompute.

---
 rtl/uart_packet_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_packet_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_rx.sv
// 8N1 UART receiver that tags each accepted byte with its position in a fixed-length packet.
// Drives the parameter register bank through read_data/idx/update_reg and flags complete packets.
module uart_packet_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned PKT_BYTES    = 60,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] read_data,
  output logic [6:0] idx,
  output logic       update_reg,
  output logic       pc_ready,
  output logic       frame_err
);

  localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TIMER_W      = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDLE_W       = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic               rx_meta;
  logic               rx_s;
  logic               rx_prev;
  logic [1:0]         state_q,     state_d;
  logic [TIMER_W-1:0] timer_q,     timer_d;
  logic [2:0]         bit_cnt_q,   bit_cnt_d;
  logic [7:0]         shift_q,     shift_d;
  logic [6:0]         byte_cnt_q,  byte_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q,  idle_cnt_d;
  logic [7:0]         read_data_d;
  logic [6:0]         idx_d;
  logic               update_d;
  logic               pc_ready_d;
  logic               frame_err_d;
  logic               fall_c;
  logic               tick_c;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall_c = rx_prev & ~rx_s;
  assign tick_c = (timer_q == TIMER_W'(1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      read_data  <= '0;
      idx        <= '0;
      update_reg <= 1'b0;
      pc_ready   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      read_data  <= read_data_d;
      idx        <= idx_d;
      update_reg <= update_d;
      pc_ready   <= pc_ready_d;
      frame_err  <= frame_err_d;
    end
  end

  // Next-state and output decode; the timer expires on the cycle it reads 1
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    read_data_d = read_data;
    idx_d       = idx;
    update_d    = 1'b0;
    frame_err_d = 1'b0;
    pc_ready_d  = update_reg && (idx == 7'(PKT_BYTES - 1));

    case (state_q)
      S_IDLE: begin
        // A falling edge beats a coinciding timeout, so the packet position survives
        if (fall_c) begin
          state_d    = S_START;
          timer_d    = TIMER_W'(CLKS_PER_BIT / 2);
          idle_cnt_d = '0;
        end else if (byte_cnt_q != 7'd0) begin
          if (idle_cnt_q == IDLE_W'(TIMEOUT_CLKS - 1)) begin
            byte_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            timer_d   = TIMER_W'(CLKS_PER_BIT);
            bit_cnt_d = '0;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_d   = {rx_s, shift_q[7:1]};
          timer_d   = TIMER_W'(CLKS_PER_BIT);
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_STOP: begin
        // Return to IDLE mid stop bit so back-to-back start bits are caught
        if (tick_c) begin
          state_d = S_IDLE;
          if (rx_s) begin
            read_data_d = shift_q;
            idx_d       = byte_cnt_q;
            update_d    = 1'b1;
            if (byte_cnt_q == 7'(PKT_BYTES - 1)) begin
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 7'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: directed vector table, hand-written corner sequences,
// and randomized byte streams checked against a packet-position model.
module tb_uart_packet_rx;

  localparam int CPB     = 8;
  localparam int PKT     = 60;
  localparam int TOB     = 32;
  localparam int TO_CLKS = TOB * CPB;
  localparam int K_UPD   = 0;
  localparam int K_FE    = 1;
  localparam int K_PC    = 2;
  // Nominal clocks from the rx line edge to update_reg: half bit + 9 bits + output flop + 2 sync flops
  localparam int LAT_NOM = CPB / 2 + 9 * CPB + 1 + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] read_data;
  logic [6:0] idx;
  logic       update_reg;
  logic       pc_ready;
  logic       frame_err;

  uart_packet_rx #(
    .CLKS_PER_BIT(CPB),
    .PKT_BYTES   (PKT),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .read_data (read_data),
    .idx       (idx),
    .update_reg(update_reg),
    .pc_ready  (pc_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [6:0] idx;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    int         exp_kind;
    logic [6:0] exp_idx;
    logic [7:0] exp_rd;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   idle_acc = 0;
  int   last_start_cyc = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe seen on the outputs
  always @(negedge clk) begin
    if (rst_n) begin
      if (update_reg || frame_err) begin
        checks++;
        if (update_reg && frame_err) begin
          failures++;
          $display("FAIL strobe_exclusive at cycle %0d: update_reg=1 frame_err=1, required at most one", cyc);
        end
      end
      if (update_reg) obs_q.push_back('{kind: K_UPD, data: read_data, idx: idx, cyc: cyc});
      if (frame_err)  obs_q.push_back('{kind: K_FE,  data: read_data, idx: idx, cyc: cyc});
      if (pc_ready)   obs_q.push_back('{kind: K_PC,  data: read_data, idx: idx, cyc: cyc});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
    idle_acc += n;
  endtask

  // Packet-position model: one call per byte put on the line
  task automatic model_byte(input logic [7:0] d, input bit ok);
    if (model_cnt != 0 && idle_acc + CPB / 2 >= TO_CLKS) model_cnt = 0;
    idle_acc = 0;
    if (ok) begin
      exp_q.push_back('{kind: K_UPD, data: d, idx: 7'(model_cnt), cyc: 0});
      if (model_cnt == PKT - 1) begin
        exp_q.push_back('{kind: K_PC, data: 8'h00, idx: 7'd0, cyc: 0});
        model_cnt = 0;
      end else begin
        model_cnt++;
      end
    end else begin
      exp_q.push_back('{kind: K_FE, data: 8'h00, idx: 7'd0, cyc: 0});
      model_cnt = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int gap);
    model_byte(d, stop_ok);
    last_start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    idle(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    model_cnt = 0;
    idle_acc  = 0;
    idle(4);
  endtask

  task automatic check_events(input string tag);
    ev_t o;
    ev_t e;
    int  prev_cyc;
    int  n;
    chk($sformatf("%s event_count", tag), obs_q.size(), exp_q.size());
    prev_cyc = -100;
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s ev%0d kind", tag, n), o.kind, e.kind);
      if (e.kind == K_UPD && o.kind == K_UPD) begin
        chk($sformatf("%s ev%0d read_data", tag, n), int'(o.data), int'(e.data));
        chk($sformatf("%s ev%0d idx", tag, n), int'(o.idx), int'(e.idx));
      end
      if (e.kind == K_PC && o.kind == K_PC)
        chk($sformatf("%s ev%0d pc_ready_delay", tag, n), o.cyc - prev_cyc, 1);
      prev_cyc = o.cyc;
      n++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    ev_t        ev;
    logic [7:0] d;
    logic [7:0] rb;
    bit         ok;
    int         g;

    // Directed table: single byte, framing error, timeout at 32 and 31 bit-times
    vecs.push_back('{8'hA5, 1'b1, 20,  K_UPD, 7'd0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b1, 10,  K_UPD, 7'd1, 8'h3C});
    vecs.push_back('{8'h5A, 1'b0, 10,  K_FE,  7'd1, 8'h3C});
    vecs.push_back('{8'h77, 1'b1, 2,   K_UPD, 7'd0, 8'h77});
    vecs.push_back('{8'h01, 1'b1, 2,   K_UPD, 7'd1, 8'h01});
    vecs.push_back('{8'h02, 1'b1, 2,   K_UPD, 7'd2, 8'h02});
    vecs.push_back('{8'h03, 1'b1, 2,   K_UPD, 7'd3, 8'h03});
    vecs.push_back('{8'h04, 1'b1, 256, K_UPD, 7'd4, 8'h04});
    vecs.push_back('{8'h42, 1'b1, 2,   K_UPD, 7'd0, 8'h42});
    vecs.push_back('{8'h10, 1'b1, 2,   K_UPD, 7'd1, 8'h10});
    vecs.push_back('{8'h11, 1'b1, 2,   K_UPD, 7'd2, 8'h11});
    vecs.push_back('{8'h12, 1'b1, 2,   K_UPD, 7'd3, 8'h12});
    vecs.push_back('{8'h13, 1'b1, 248, K_UPD, 7'd4, 8'h13});
    vecs.push_back('{8'h43, 1'b1, 10,  K_UPD, 7'd5, 8'h43});

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset read_data", int'(read_data), 0);
    chk("reset idx", int'(idx), 0);
    chk("reset update_reg", int'(update_reg), 0);
    chk("reset pc_ready", int'(pc_ready), 0);
    chk("reset frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
      if (obs_q.size() == 0) begin
        chk($sformatf("vec%0d strobe_seen", i), 0, 1);
      end else begin
        ev = obs_q.pop_front();
        chk($sformatf("vec%0d kind", i), ev.kind, vecs[i].exp_kind);
        if (ev.kind == K_UPD && vecs[i].exp_kind == K_UPD) begin
          chk($sformatf("vec%0d strobe_data", i), int'(ev.data), int'(vecs[i].data));
          chk($sformatf("vec%0d strobe_idx", i), int'(ev.idx), int'(vecs[i].exp_idx));
          chk_range($sformatf("vec%0d latency", i), ev.cyc - last_start_cyc, LAT_NOM - 1, LAT_NOM + 1);
        end
      end
      chk($sformatf("vec%0d read_data_hold", i), int'(read_data), int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d idx_hold", i), int'(idx), int'(vecs[i].exp_idx));
    end
    chk("table extra_events", obs_q.size(), 0);

    // False start: 3-clock low glitch must be ignored
    do_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    chk("false_start no_strobe", obs_q.size(), 0);
    send_byte(8'h3C, 1'b1, 5);
    check_events("after_false_start");

    // Full packet back-to-back, then one more byte wrapping to idx 0
    do_reset();
    for (int n = 0; n < PKT; n++) send_byte(8'(n), 1'b1, 0);
    send_byte(8'h11, 1'b1, 20);
    check_events("full_packet");
    chk("full_packet wrap idx", int'(idx), 0);
    chk("full_packet wrap data", int'(read_data), 8'h11);

    // Reset during data bit 3 aborts the byte in flight
    do_reset();
    send_byte(8'h12, 1'b1, 5);
    check_events("pre_reset");
    rb = 8'h99;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      rx = rb[b];
      repeat (CPB) @(negedge clk);
    end
    rx = rb[3];
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset read_data", int'(read_data), 0);
    chk("midreset idx", int'(idx), 0);
    chk("midreset update_reg", int'(update_reg), 0);
    chk("midreset pc_ready", int'(pc_ready), 0);
    chk("midreset frame_err", int'(frame_err), 0);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    model_cnt = 0;
    idle_acc  = 0;
    idle(30);
    chk("midreset no_strobe", obs_q.size(), 0);
    send_byte(8'h99, 1'b1, 5);
    check_events("after_midreset");

    // Randomized stream: mostly good bytes, occasional framing errors and long idles
    do_reset();
    for (int i = 0; i < 140; i++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 19) == 0) g = int'($urandom_range(290, 320));
      else                            g = int'($urandom_range(0, 5));
      if (!ok && g < 2) g = 2;
      send_byte(d, ok, g);
      if (i % 20 == 19) begin
        idle(3);
        check_events($sformatf("random_blk%0d", i / 20));
      end
    end
    idle(3);
    check_events("random_tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
